div_issue_ctrl: RTL

- Initiator side of the divider start/busy/finished handshake.
- Sits in the execute stage and accepts M-extension divide ops (DIV/DIVU/REM/REMU).
- Resolves divide-by-zero locally; otherwise launches the divider and holds its operands stable.
- Stalls the pipeline, captures the result on finished, and presents one writeback beat.

---
 rtl/m_ext_pkg.sv | 31 +++
 rtl/div_result_cache.sv | 45 ++++
 rtl/div_issue_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions: divide funct3 encodings, issue-controller states,
// the divide-by-zero quotient and the divider start-to-finished latency.
package m_ext_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam int unsigned DIV_LATENCY   = 34;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LAUNCH,
        WAIT,
        ZERO,
        DRAIN,
        DONE
    } div_state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry memo of the last completed divider result {funct3, rs1, rs2, result}.
// Only instantiated when DIV_RESULT_CACHE_EN is defined.
module div_result_cache #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic [2:0]      wr_op_i,
    input  logic [XLEN-1:0] wr_a_i,
    input  logic [XLEN-1:0] wr_b_i,
    input  logic [XLEN-1:0] wr_res_i,
    input  logic [2:0]      lk_op_i,
    input  logic [XLEN-1:0] lk_a_i,
    input  logic [XLEN-1:0] lk_b_i,
    output logic            hit_c_o,
    output logic [XLEN-1:0] res_o
);

    logic            vld_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else if (wr_en_i) begin
            vld_q <= 1'b1;
            op_q  <= wr_op_i;
            a_q   <= wr_a_i;
            b_q   <= wr_b_i;
            res_q <= wr_res_i;
        end
    end

    assign hit_c_o = vld_q && (op_q == lk_op_i) && (a_q == lk_a_i) && (b_q == lk_b_i);
    assign res_o   = res_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for DIV/DIVU/REM/REMU: resolves /0 locally, otherwise drives the
// divider start/busy/finished handshake. Optional last-result memo under DIV_RESULT_CACHE_EN.
module div_issue_ctrl
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            dv_start,
    output logic [2:0]      dv_div_op,
    output logic [XLEN-1:0] dv_dividend,
    output logic [XLEN-1:0] dv_divisor,
    input  logic            dv_busy,
    input  logic            dv_finished,
    input  logic [XLEN-1:0] dv_result
);

    div_state_e      state_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [RD_W-1:0] rd_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            start_q;
    logic            wb_valid_q;
    logic            fin_wait_q;
    logic            hit_q;

    logic            req_ok_c;
    logic            cache_hit_c;
    logic [XLEN-1:0] cache_res_c;

    assign req_ok_c = req_valid && is_div_op(req_funct3);

`ifdef DIV_RESULT_CACHE_EN
    logic cache_wr_c;

    assign cache_wr_c = (state_q == WAIT) && dv_finished && !flush;

    div_result_cache #(.XLEN(XLEN)) u_cache (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (cache_wr_c),
        .wr_op_i  (op_q),
        .wr_a_i   (a_q),
        .wr_b_i   (b_q),
        .wr_res_i (dv_result),
        .lk_op_i  (req_funct3),
        .lk_a_i   (req_rs1),
        .lk_b_i   (req_rs2),
        .hit_c_o  (cache_hit_c),
        .res_o    (cache_res_c)
    );
`else
    assign cache_hit_c = 1'b0;
    assign cache_res_c = '0;
`endif

    // Issue FSM; fin_wait_q tells DRAIN whether a start actually reached the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            fin_wait_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ok_c) begin
                        op_q  <= req_funct3;
                        a_q   <= req_rs1;
                        b_q   <= req_rs2;
                        rd_q  <= req_rd;
                        hit_q <= cache_hit_c;
                        if ((req_rs2 == '0) || cache_hit_c) begin
                            state_q <= ZERO;
                        end else if (dv_busy) begin
                            state_q <= SYNC;
                        end else begin
                            state_q <= LAUNCH;
                            start_q <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (!dv_busy) begin
                        state_q <= LAUNCH;
                        start_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (flush) begin
                        state_q    <= DRAIN;
                        fin_wait_q <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_q    <= dv_finished ? IDLE : DRAIN;
                        fin_wait_q <= 1'b1;
                    end else if (dv_finished) begin
                        wb_data_q  <= dv_result;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                ZERO: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        wb_data_q  <= hit_q ? cache_res_c
                                    : (is_rem_op(op_q) ? a_q : XLEN'(DIV_ZERO_QUOT));
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DRAIN: begin
                    if (fin_wait_q ? dv_finished : !dv_busy) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A flush landing on the LAUNCH or DONE cycle must still squash the pulse it coincides with.
    assign dv_start    = start_q && !flush;
    assign wb_valid    = wb_valid_q && !flush;
    assign stall       = (state_q == IDLE) ? req_ok_c : (state_q != DONE);
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign dv_div_op   = op_q;
    assign dv_dividend = a_q;
    assign dv_divisor  = b_q;

endmodule
